// File: rtl/rw_core_sched.sv
`default_nettype none
// ============================================================================
//  Module      : rw_core_sched
//  Description : Round-robin scheduler that time-shares one combinational
//                core step among N_REQ requesters, each with its own context.
//  Revision    : 1.0 - initial release
// ============================================================================
module rw_core_sched #(
    parameter int              N_REQ    = 4,
    parameter int              DW       = 8,
    parameter int              SW       = 10,
    parameter logic [SW-1:0]   INIT_CTX = 10'h100
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*DW-1:0]        req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       resp_valid,
    output logic [DW-1:0]              resp_data,
    output logic [$clog2(N_REQ)-1:0]   resp_id,
    output logic                       resp_halt,
    input  logic                       resp_ready,
    input  logic [N_REQ-1:0]           ctx_clr,
    output logic [DW-1:0]              core_in,
    output logic [SW-1:0]              core_ctx,
    input  logic [DW-1:0]              core_out,
    input  logic [SW-1:0]              core_ctx_nxt,
    input  logic                       core_cont
);

    localparam int IW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IW-1:0]       r_rr_ptr;
    logic [IW-1:0]       r_idx;
    logic [DW-1:0]       r_data;
    logic [DW-1:0]       r_resp_data;
    logic [IW-1:0]       r_resp_id;
    logic                r_resp_halt;

    logic [DW-1:0]       w_req_word [N_REQ];
    logic [SW-1:0]       w_ctx      [N_REQ];
    logic                w_grant_vld;
    logic [IW-1:0]       w_grant_idx;
    logic [IW-1:0]       w_ptr_nxt;
    logic [IW:0]         w_sum;

    // Per-requester input word slices and context registers.
    for (genvar i = 0; i < N_REQ; i++) begin : g_req
        logic [SW-1:0] r_ctx;

        assign w_req_word[i] = req_data[i*DW +: DW];
        assign w_ctx[i]      = r_ctx;

        // A clear overrides a coinciding write-back of the same requester.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_ctx <= INIT_CTX;
            end else if (ctx_clr[i]) begin
                r_ctx <= INIT_CTX;
            end else if (r_state == ST_RUN && r_idx == IW'(i)) begin
                r_ctx <= core_cont ? core_ctx_nxt : INIT_CTX;
            end
        end
    end

    // Descending scan so the last hit is the closest one at/after r_rr_ptr.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_sum       = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr_ptr} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(N_REQ)) begin
                w_sum = w_sum - (IW+1)'(N_REQ);
            end
            if (req_valid[w_sum[IW-1:0]]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_sum[IW-1:0];
            end
        end
    end

    assign w_ptr_nxt = (w_grant_idx == IW'(N_REQ - 1)) ? '0 : w_grant_idx + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        resp_valid  = 1'b0;
        core_in     = '0;
        core_ctx    = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_vld) begin
                    w_state_nxt = ST_RUN;
                end
                // Gated by rst so nothing is offered while reset is held.
                if (w_grant_vld && rst) begin
                    req_ready[w_grant_idx] = 1'b1;
                end
            end
            ST_RUN: begin
                w_state_nxt = ST_HOLD;
                core_in     = r_data;
                core_ctx    = w_ctx[r_idx];
            end
            ST_HOLD: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr    <= '0;
            r_idx       <= '0;
            r_data      <= '0;
            r_resp_data <= '0;
            r_resp_id   <= '0;
            r_resp_halt <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && w_grant_vld) begin
                r_data   <= w_req_word[w_grant_idx];
                r_idx    <= w_grant_idx;
                r_rr_ptr <= w_ptr_nxt;
            end
            if (r_state == ST_RUN) begin
                r_resp_data <= core_out;
                r_resp_id   <= r_idx;
                r_resp_halt <= ~core_cont;
            end
        end
    end

    assign resp_data = r_resp_data;
    assign resp_id   = r_resp_id;
    assign resp_halt = r_resp_halt;

endmodule
`default_nettype wire

// File: tb/tb_rw_core_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rw_core_sched
//  Description : Directed self-checking bench for rw_core_sched.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rw_core_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        resp_valid;
    logic [7:0]  resp_data;
    logic [1:0]  resp_id;
    logic        resp_halt;
    logic        resp_ready;
    logic [3:0]  ctx_clr;
    logic [7:0]  core_in;
    logic [9:0]  core_ctx;
    logic [7:0]  core_out;
    logic [9:0]  core_ctx_nxt;
    logic        core_cont;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Reference core behaviour.
    assign core_out     = core_in + core_ctx[7:0];
    assign core_ctx_nxt = {2'h1, core_in};
    assign core_cont    = (core_in != 8'hFF);

    rw_core_sched #(
        .N_REQ    (4),
        .DW       (8),
        .SW       (10),
        .INIT_CTX (10'h100)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .resp_id      (resp_id),
        .resp_halt    (resp_halt),
        .resp_ready   (resp_ready),
        .ctx_clr      (ctx_clr),
        .core_in      (core_in),
        .core_ctx     (core_ctx),
        .core_out     (core_out),
        .core_ctx_nxt (core_ctx_nxt),
        .core_cont    (core_cont)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction with resp_ready held high.
    task automatic txn(input int idx, input logic [7:0] d, input logic [9:0] ectx,
                       input logic [7:0] eout, input logic ehalt, input bit clr);
        logic [3:0] m;
        m = 4'(1 << idx);
        req_valid = m;
        req_data[idx*8 +: 8] = d;
        resp_ready = 1'b1;
        #1;
        chk("grant", {28'h0, req_ready}, {28'h0, m});
        step();
        req_valid = 4'b0000;
        chk("run_ready", {28'h0, req_ready}, 32'h0);
        chk("run_core_in", {24'h0, core_in}, {24'h0, d});
        chk("run_core_ctx", {22'h0, core_ctx}, {22'h0, ectx});
        chk("run_resp_valid", {31'h0, resp_valid}, 32'h0);
        if (clr) ctx_clr = m;
        step();
        ctx_clr = 4'b0000;
        chk("hold_resp_valid", {31'h0, resp_valid}, 32'h1);
        chk("hold_resp_data", {24'h0, resp_data}, {24'h0, eout});
        chk("hold_resp_id", {30'h0, resp_id}, 32'(idx));
        chk("hold_resp_halt", {31'h0, resp_halt}, {31'h0, ehalt});
        step();
        chk("idle_resp_valid", {31'h0, resp_valid}, 32'h0);
    endtask

    initial begin
        logic [7:0] rr_exp;
        rst        = 1'b0;
        req_valid  = 4'b1111;
        req_data   = 32'h0;
        resp_ready = 1'b1;
        ctx_clr    = 4'b0000;
        step();
        step();
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_req_ready", {28'h0, req_ready}, 32'h0);
        chk("rst_resp_data", {24'h0, resp_data}, 32'h0);
        chk("rst_resp_id", {30'h0, resp_id}, 32'h0);
        chk("rst_resp_halt", {31'h0, resp_halt}, 32'h0);
        chk("rst_core_in", {24'h0, core_in}, 32'h0);
        chk("rst_core_ctx", {22'h0, core_ctx}, 32'h0);
        req_valid = 4'b0000;
        rst = 1'b1;
        step();
        step();
        chk("idle_no_req", {28'h0, req_ready}, 32'h0);

        // Single request, then context persistence for requester 0.
        txn(0, 8'h05, 10'h100, 8'h05, 1'b0, 1'b0);
        txn(0, 8'h10, 10'h105, 8'h15, 1'b0, 1'b0);
        // Requester 2 accumulates context across requests.
        txn(2, 8'h03, 10'h100, 8'h03, 1'b0, 1'b0);
        txn(2, 8'h04, 10'h103, 8'h07, 1'b0, 1'b0);
        // Halt restores the initial context.
        txn(1, 8'hFF, 10'h100, 8'hFF, 1'b1, 1'b0);
        txn(1, 8'h01, 10'h100, 8'h01, 1'b0, 1'b0);

        // Backpressure on requester 3 while requester 2 waits.
        req_valid = 4'b1000;
        req_data[31:24] = 8'h20;
        resp_ready = 1'b0;
        #1;
        chk("bp_grant", {28'h0, req_ready}, 32'h8);
        step();
        req_valid = 4'b0100;
        req_data[23:16] = 8'h11;
        chk("bp_run_ready", {28'h0, req_ready}, 32'h0);
        step();
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", {31'h0, resp_valid}, 32'h1);
            chk("bp_data", {24'h0, resp_data}, 32'h20);
            chk("bp_id", {30'h0, resp_id}, 32'h3);
            chk("bp_halt", {31'h0, resp_halt}, 32'h0);
            chk("bp_ready", {28'h0, req_ready}, 32'h0);
            step();
        end
        resp_ready = 1'b1;
        #1;
        chk("bp_release_valid", {31'h0, resp_valid}, 32'h1);
        step();
        chk("bp_next_grant", {28'h0, req_ready}, 32'h4);
        step();
        req_valid = 4'b0000;
        chk("bp_next_core_in", {24'h0, core_in}, 32'h11);
        chk("bp_next_core_ctx", {22'h0, core_ctx}, 32'h104);
        step();
        chk("bp_next_data", {24'h0, resp_data}, 32'h15);
        chk("bp_next_id", {30'h0, resp_id}, 32'h2);
        step();

        // Clear collides with write-back of requester 0.
        txn(0, 8'h30, 10'h110, 8'h40, 1'b0, 1'b1);

        // Next request shows the clear won; reset dropped during HOLD.
        req_valid = 4'b0001;
        req_data[7:0] = 8'h01;
        #1;
        chk("clr_grant", {28'h0, req_ready}, 32'h1);
        step();
        req_valid = 4'b0000;
        chk("clr_ctx0", {22'h0, core_ctx}, 32'h100);
        step();
        chk("pre_rst_valid", {31'h0, resp_valid}, 32'h1);
        rst = 1'b0;
        #1;
        chk("async_rst_valid", {31'h0, resp_valid}, 32'h0);
        step();
        rst = 1'b1;
        req_valid = 4'b1111;
        req_data  = 32'h04030201;

        // Round-robin from requester 0 after reset, one grant per 3 cycles.
        for (int g = 0; g < 5; g++) begin
            logic [3:0] m;
            int e;
            e = g % 4;
            m = 4'(1 << e);
            rr_exp = (g == 4) ? 8'h02 : 8'(e + 1);
            #1;
            chk("rr_grant", {28'h0, req_ready}, {28'h0, m});
            step();
            chk("rr_run_ready", {28'h0, req_ready}, 32'h0);
            chk("rr_core_ctx", {22'h0, core_ctx}, (g == 4) ? 32'h101 : 32'h100);
            step();
            chk("rr_hold_ready", {28'h0, req_ready}, 32'h0);
            chk("rr_resp_id", {30'h0, resp_id}, 32'(e));
            chk("rr_resp_data", {24'h0, resp_data}, {24'h0, rr_exp});
            step();
        end
        req_valid = 4'b0000;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
